// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   INSTR_W       : instruction width
//   PC_W          : PC width carried in each fetch-queue entry
//   NOP_INSTR     : instruction presented when the queue is empty (addi x0,x0,0)
//   fetch_entry_t : one queued fetch result, {pc, instr}
package if_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t with a flush input.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   clear      : drop all entries; wins over push and pop in the same cycle
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   count      : number of valid entries, 0..DEPTH
//   head       : entry at the read pointer (contents undefined when count==0)
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage_q.sv
// Instruction-fetch stage with a prefetch queue and valid/ready output.
// Drives a 1-cycle-latency synchronous instruction memory, tags each returned
// word with its PC and buffers up to FQ_DEPTH entries for decode.
//   clk, reset     : clock, synchronous active-high reset
//   redirect_valid : branch/flush, kills in-flight and queued fetches
//   redirect_pc    : restart address (bits [1:0] ignored)
//   imem_en        : memory read request this cycle
//   imem_addr      : word address of the request
//   imem_rdata     : read data, valid the cycle after imem_en
//   out_valid      : queue head holds an instruction
//   out_ready      : decode accepts the head this cycle
//   out_pc         : PC of the head (0 when out_valid=0)
//   out_instr      : head instruction (NOP when out_valid=0)
module if_stage_q
  import if_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               IMEM_AW  = 10,
  parameter int               FQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_p0;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occupancy;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;
  logic            push;
  logic            pop;

  // Outstanding work = queued entries plus the word still in the memory.
  // A same-cycle pop earns no credit, keeping the issue path short.
  assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, vld_p1};
  assign imem_en   = !reset && !redirect_valid && (occupancy < (CW+1)'(FQ_DEPTH));
  assign imem_addr = fetch_pc_p0[IMEM_AW+1:2];

  // ---- p0 -> p1: request issued, word returns next cycle ----
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= redirect_pc & ~XLEN'(3);
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= imem_en;
      if (imem_en) fetch_pc_p0 <= fetch_pc_p0 + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_en) pc_p1 <= fetch_pc_p0;
  end

  // ---- p1 -> queue: returned word tagged with its PC ----
  assign push              = vld_p1 && !redirect_valid && !reset;
  assign q_push_data.pc    = PC_W'(pc_p1);
  assign q_push_data.instr = imem_rdata;

  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready;

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .count     (q_count),
    .head      (q_head)
  );

  assign out_pc    = out_valid ? XLEN'(q_head.pc) : '0;
  assign out_instr = out_valid ? q_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_stage_q.sv
module tb_if_stage_q;

  localparam int          XLEN     = 32;
  localparam int          IMEM_AW  = 10;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic               clk;
  logic               reset;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        out_instr;

  if_stage_q #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .IMEM_AW  (IMEM_AW),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM; garbage on idle cycles so an unrequested word is visible.
  logic [31:0] rom [1024];
  always @(posedge clk) imem_rdata <= imem_en ? rom[imem_addr] : $urandom;

  int n_cmp;
  int n_err;

  // Reference model: next PC the stream must deliver, next PC to be
  // requested, and outstanding fetches (issued but not yet consumed).
  logic [31:0] exp_out_pc;
  logic [31:0] exp_issue_pc;
  int          occ;

  logic               obs_en;
  logic [IMEM_AW-1:0] obs_addr;
  logic               obs_valid;
  logic [31:0]        obs_pc;
  logic [31:0]        obs_instr;

  // One clock: sample mid-cycle, score against the model, then advance it.
  task automatic cycle();
    logic squash, exp_en, acc;
    @(negedge clk);
    obs_en    = imem_en;
    obs_addr  = imem_addr;
    obs_valid = out_valid;
    obs_pc    = out_pc;
    obs_instr = out_instr;
    squash = reset || redirect_valid;
    exp_en = !squash && (occ < FQ_DEPTH);
    n_cmp++;
    if (obs_en !== exp_en) begin
      n_err++; $display("FAIL issue_rule: imem_en=%b expected %b (occ=%0d)", obs_en, exp_en, occ);
    end
    if (obs_en === 1'b1) begin
      n_cmp++;
      if (obs_addr !== exp_issue_pc[11:2]) begin
        n_err++; $display("FAIL issue_addr: got %h expected %h", obs_addr, exp_issue_pc[11:2]);
      end
    end
    if (obs_valid === 1'b1) begin
      n_cmp++;
      if (obs_instr !== rom[obs_pc[11:2]]) begin
        n_err++; $display("FAIL tag: pc %h instr %h expected %h", obs_pc, obs_instr, rom[obs_pc[11:2]]);
      end
    end else begin
      n_cmp++;
      if (obs_pc !== 32'h0 || obs_instr !== NOP || obs_valid !== 1'b0) begin
        n_err++; $display("FAIL idle_out: valid %b pc %h instr %h expected 0/0/%h", obs_valid, obs_pc, obs_instr, NOP);
      end
    end
    acc = (obs_valid === 1'b1) && out_ready;
    if (acc && !squash) begin
      n_cmp++;
      if (obs_pc !== exp_out_pc) begin
        n_err++; $display("FAIL order: pc %h expected %h", obs_pc, exp_out_pc);
      end
    end
    @(posedge clk);
    if (reset) begin
      exp_out_pc = RESET_PC; exp_issue_pc = RESET_PC; occ = 0;
    end else if (redirect_valid) begin
      exp_out_pc = redirect_pc & ~32'h3; exp_issue_pc = redirect_pc & ~32'h3; occ = 0;
    end else begin
      if (obs_en === 1'b1) begin occ++; exp_issue_pc += 32'd4; end
      if (acc) begin occ--; exp_out_pc += 32'd4; end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    cycle(); cycle();
    n_cmp++;
    if (obs_en !== 1'b0 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_state: en %b valid %b expected 0 0", obs_en, obs_valid);
    end
    reset = 1'b0;
    cycle();
    n_cmp++;
    if (obs_en !== 1'b1 || obs_addr !== 10'h000 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL cold_issue: en %b addr %h valid %b expected 1 000 0", obs_en, obs_addr, obs_valid);
    end
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b0) begin
      n_err++; $display("FAIL cold_latency: valid %b expected 0", obs_valid);
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * i) || obs_instr !== 32'hA000_0000 + 32'(i)) begin
        n_err++; $display("FAIL cold_stream: valid %b pc %h instr %h expected 1 %h %h",
                          obs_valid, obs_pc, obs_instr, 32'(4 * i), 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    int          occ0, issues;
    logic [31:0] head;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    occ0 = occ; issues = 0;
    out_ready = 1'b0;
    cycle();
    head = obs_pc; issues += int'(obs_en);
    for (int i = 1; i < 10; i++) begin
      cycle();
      issues += int'(obs_en);
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_pc !== head) begin
        n_err++; $display("FAIL stall_hold: valid %b pc %h expected 1 %h", obs_valid, obs_pc, head);
      end
      if (i >= 5) begin
        n_cmp++;
        if (obs_en !== 1'b0) begin
          n_err++; $display("FAIL stall_no_issue: en %b expected 0", obs_en);
        end
      end
    end
    n_cmp++;
    if (issues != FQ_DEPTH - occ0) begin
      n_err++; $display("FAIL fill_level: issues %0d expected %0d", issues, FQ_DEPTH - occ0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_cmp++;
      if (obs_valid !== 1'b1) begin
        n_err++; $display("FAIL release_stream: valid %b expected 1", obs_valid);
      end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    n_cmp++;
    if (obs_en !== 1'b0) begin
      n_err++; $display("FAIL redir_no_issue: en %b expected 0", obs_en);
    end
    redirect_valid = 1'b0;
    cycle();
    n_cmp++;
    if (obs_en !== 1'b1 || obs_addr !== 10'h040 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_issue: en %b addr %h valid %b expected 1 040 0", obs_en, obs_addr, obs_valid);
    end
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_gap: valid %b expected 0", obs_valid);
    end
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h100) begin
      n_err++; $display("FAIL redir_first: valid %b pc %h expected 1 00000100", obs_valid, obs_pc);
    end
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h104) begin
      n_err++; $display("FAIL redir_second: valid %b pc %h expected 1 00000104", obs_valid, obs_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic seen_stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    n_cmp++;
    if (obs_en !== 1'b0) begin
      n_err++; $display("FAIL b2b_no_issue: en %b expected 0", obs_en);
    end
    redirect_valid = 1'b0;
    cycle();
    n_cmp++;
    if (obs_en !== 1'b1 || obs_addr !== 10'h0C0 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_issue: en %b addr %h valid %b expected 1 0c0 0", obs_en, obs_addr, obs_valid);
    end
    cycle();
    seen_stale = (obs_valid === 1'b1);
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h300) begin
      n_err++; $display("FAIL b2b_first: valid %b pc %h expected 1 00000300", obs_valid, obs_pc);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (obs_valid === 1'b1 && obs_pc[31:4] == 28'h020) seen_stale = 1'b1;
    end
    n_cmp++;
    if (seen_stale !== 1'b0) begin
      n_err++; $display("FAIL b2b_stale: stale output seen %b expected 0", seen_stale);
    end
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    reset = 1'b1; out_ready = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b0 || obs_en !== 1'b1 || obs_addr !== 10'h000) begin
      n_err++; $display("FAIL rst_mid: valid %b en %b addr %h expected 0 1 000", obs_valid, obs_en, obs_addr);
    end
    cycle();
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== RESET_PC) begin
      n_err++; $display("FAIL rst_restart: valid %b pc %h expected 1 %h", obs_valid, obs_pc, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    n_cmp++;
    if (obs_en !== 1'b1 || obs_addr !== 10'h3FF) begin
      n_err++; $display("FAIL wrap_addr_hi: en %b addr %h expected 1 3ff", obs_en, obs_addr);
    end
    cycle();
    n_cmp++;
    if (obs_en !== 1'b1 || obs_addr !== 10'h000) begin
      n_err++; $display("FAIL wrap_addr_lo: en %b addr %h expected 1 000", obs_en, obs_addr);
    end
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'hFFC || obs_instr !== rom[1023]) begin
      n_err++; $display("FAIL wrap_first: pc %h instr %h expected 00000ffc %h", obs_pc, obs_instr, rom[1023]);
    end
    cycle();
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_pc !== 32'h1000 || obs_instr !== rom[0]) begin
      n_err++; $display("FAIL wrap_second: pc %h instr %h expected 00001000 %h", obs_pc, obs_instr, rom[0]);
    end
  endtask

  task automatic test_random();
    reset = 1'b1; redirect_valid = 1'b0;
    cycle();
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    exp_out_pc = RESET_PC; exp_issue_pc = RESET_PC; occ = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_midstream_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
